// File: rtl/apb_slave_regs.sv
// apb_slave_regs
//   APB3 slave fronting a generic register bank: address decode, programmable
//   wait states, PSLVERR, read-back mux and per-register one-hot strobes.
//
// Optional feature (macro APB_PSTRB_EN):
//   defined   -> adds pstrb; writes update only enabled byte lanes, and a read
//                with any pstrb bit set is an error.
//   undefined -> no pstrb port; writes update the full word.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         APB byte address / write data
//   pstrb                 byte-lane write strobes (APB_PSTRB_EN only)
//   prdata, pready        read data (0 unless completing read), completion
//   pslverr               error response, qualified by pready
//   reg_out               flattened writable registers (RO slices held at 0)
//   reg_in                flattened read-back values for read-only registers
//   wr_en, rd_en          one-hot strobes, one cycle after a good completion
module apb_slave_regs #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 8,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]        pstrb,
`endif
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    output logic [NUM_REGS-1:0]        wr_en,
    output logic [NUM_REGS-1:0]        rd_en
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state, state_nxt;
    logic                setup, complete;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] strb_q;
`endif
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [IDX_W-1:0]    idx;
    logic [NUM_REGS-1:0] sel;
    logic                err;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   wr_val;

    // ---------------- FSM ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        setup     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                // penable without a preceding SETUP is ignored here
                if (psel && !penable) begin
                    setup     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0 && penable) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- Decode / read mux ----------------
    assign idx = addr_q[ADDR_W-1:2];

    // sel is empty for an index beyond the bank, which doubles as the range check
    always_comb begin
        sel     = '0;
        rd_val  = '0;
        cur_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sel[i] = (32'(idx) == i);
            if (sel[i]) begin
                rd_val  = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs[i];
                cur_val = regs[i];
            end
        end
    end

    always_comb begin
        err = (addr_q[1:0] != 2'b00) || (sel == '0) || (write_q && ((sel & RO_MASK) != '0));
`ifdef APB_PSTRB_EN
        err = err || (!write_q && (strb_q != '0));
`endif
    end

    always_comb begin
        wr_val = wdata_q;
`ifdef APB_PSTRB_EN
        for (int unsigned b = 0; b < DATA_W/8; b++)
            wr_val[b*8 +: 8] = strb_q[b] ? wdata_q[b*8 +: 8] : cur_val[b*8 +: 8];
`endif
    end

    assign pready  = complete;
    assign pslverr = complete && err;
    assign prdata  = (complete && !write_q && !err) ? rd_val : '0;

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef APB_PSTRB_EN
            strb_q  <= '0;
`endif
            wr_en   <= '0;
            rd_en   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_en <= '0;
            rd_en <= '0;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
`ifdef APB_PSTRB_EN
                strb_q  <= pstrb;
`endif
                cnt     <= 4'(WAIT_STATES);
            end else if (state == ACCESS && psel && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (complete && !err) begin
                if (write_q) begin
                    wr_en <= sel;
                    for (int unsigned i = 0; i < NUM_REGS; i++)
                        if (sel[i]) regs[i] <= wr_val;
                end else begin
                    rd_en <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed testbench for apb_slave_regs: one instance with zero wait states
// and register 2 read-only, one with three wait states.
module tb_apb_slave_regs;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic              psel0, psel1, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [NR*DW-1:0]  reg_in;
`ifdef APB_PSTRB_EN
    logic [DW/8-1:0]   pstrb;
    logic [DW/8-1:0]   wr_strb;
`endif

    logic [DW-1:0]     prdata0, prdata1;
    logic              pready0, pready1, pslverr0, pslverr1;
    logic [NR*DW-1:0]  reg_out0, reg_out1;
    logic [NR-1:0]     wr_en0, wr_en1, rd_en0, rd_en1;

    apb_slave_regs #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(8'b0000_0100)
    ) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .reg_out(reg_out0),
        .reg_in(reg_in), .wr_en(wr_en0), .rd_en(rd_en0)
    );

    apb_slave_regs #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(8'b0000_0000)
    ) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .reg_out(reg_out1),
        .reg_in(reg_in), .wr_en(wr_en1), .rd_en(rd_en1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] rd;
    logic          err;
    int            waits;
    logic [NR-1:0] wstb, rstb;

    // Full transfer on instance d; starts just after a rising edge, ends just
    // after the rising edge that follows the strobe cycle.
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rdat,
                        output logic e, output int nw,
                        output logic [NR-1:0] ws, output logic [NR-1:0] rs);
        logic done;
        logic bad;
        done = 1'b0; bad = 1'b0; nw = 0; rdat = '0; e = 1'b0;
        paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0;
`ifdef APB_PSTRB_EN
        pstrb = wr ? wr_strb : '0;
`endif
        if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge sys_clk);
            if ((d == 0) ? pready0 : pready1) begin
                done = 1'b1;
                rdat = (d == 0) ? prdata0 : prdata1;
                e    = (d == 0) ? pslverr0 : pslverr1;
            end else begin
                nw++;
                if (((d == 0) ? prdata0 : prdata1) != '0 ||
                    ((d == 0) ? pslverr0 : pslverr1)) bad = 1'b1;
            end
            @(posedge sys_clk); #1;
        end
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        check("xfer_done", done, 1'b1);
        check("wait_outputs_quiet", bad, 1'b0);
        @(negedge sys_clk);
        ws = (d == 0) ? wr_en0 : wr_en1;
        rs = (d == 0) ? rd_en0 : rd_en1;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        logic flag;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        reg_in = '0;
        reg_in[2*DW +: DW] = 32'h0000_0055;
`ifdef APB_PSTRB_EN
        pstrb = '0; wr_strb = '1;
`endif
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        @(negedge sys_clk);
        check("rst_pready",  pready0,  1'b0);
        check("rst_pslverr", pslverr0, 1'b0);
        check("rst_prdata",  prdata0,  '0);
        check("rst_strobes", {wr_en0, rd_en0, wr_en1, rd_en1}, '0);
        check("rst_regs",    (reg_out0 == '0) && (reg_out1 == '0), 1'b1);
        @(posedge sys_clk); #1;

        // zero-wait write
        xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, rd, err, waits, wstb, rstb);
        check("w0_waits", waits, 0);
        check("w0_err",   err, 1'b0);
        check("w0_wr_en", wstb, 8'b0000_0010);
        check("w0_rd_en", rstb, 8'b0000_0000);
        check("w0_reg1",  reg_out0[1*DW +: DW], 32'hDEAD_BEEF);

        xfer(0, 1'b0, 8'h04, 32'h0, rd, err, waits, wstb, rstb);
        check("r0_data",  rd, 32'hDEAD_BEEF);
        check("r0_rd_en", rstb, 8'b0000_0010);

        // read-only register 2
        xfer(0, 1'b0, 8'h08, 32'h0, rd, err, waits, wstb, rstb);
        check("ro_rd_data", rd, 32'h0000_0055);
        check("ro_rd_err",  err, 1'b0);
        check("ro_rd_en",   rstb, 8'b0000_0100);
        xfer(0, 1'b1, 8'h08, 32'h1234_5678, rd, err, waits, wstb, rstb);
        check("ro_wr_err",  err, 1'b1);
        check("ro_wr_en",   wstb, 8'b0000_0000);
        check("ro_reg_out", reg_out0[2*DW +: DW], 32'h0);

        // decode errors
        xfer(0, 1'b0, 8'h22, 32'h0, rd, err, waits, wstb, rstb);
        check("misal_err",  err, 1'b1);
        check("misal_data", rd, 32'h0);
        check("misal_stb",  {wstb, rstb}, 16'h0);
        xfer(0, 1'b0, 8'h40, 32'h0, rd, err, waits, wstb, rstb);
        check("range_rd_err",  err, 1'b1);
        check("range_rd_data", rd, 32'h0);
        check("range_rd_stb",  {wstb, rstb}, 16'h0);
        xfer(0, 1'b1, 8'h40, 32'hFFFF_FFFF, rd, err, waits, wstb, rstb);
        check("range_wr_err",  err, 1'b1);
        check("range_wr_stb",  {wstb, rstb}, 16'h0);
        check("range_wr_regs", reg_out0[1*DW +: DW], 32'hDEAD_BEEF);

        // back-to-back zero-wait writes to reg 0 and reg 3
`ifdef APB_PSTRB_EN
        pstrb = '1;
`endif
        paddr = 8'h00; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; psel0 = 1'b1; penable = 1'b0;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(negedge sys_clk); check("b2b_rdy1", pready0, 1'b1);
        @(posedge sys_clk); #1;
        paddr = 8'h0C; pwdata = 32'h5A5A_5A5A; penable = 1'b0;
        @(negedge sys_clk);
        check("b2b_wr1",    wr_en0, 8'b0000_0001);
        check("b2b_setup",  pready0, 1'b0);
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(negedge sys_clk); check("b2b_rdy2", pready0, 1'b1);
        @(posedge sys_clk); #1;
        psel0 = 1'b0; penable = 1'b0;
        @(negedge sys_clk);
        check("b2b_wr2",  wr_en0, 8'b0000_1000);
        check("b2b_reg0", reg_out0[0*DW +: DW], 32'hA5A5_A5A5);
        check("b2b_reg3", reg_out0[3*DW +: DW], 32'h5A5A_5A5A);
        @(posedge sys_clk); #1;

`ifdef APB_PSTRB_EN
        wr_strb = 4'b1111;
        xfer(0, 1'b1, 8'h00, 32'h1122_3344, rd, err, waits, wstb, rstb);
        wr_strb = 4'b0101;
        xfer(0, 1'b1, 8'h00, 32'hAABB_CCDD, rd, err, waits, wstb, rstb);
        check("strb_reg0", reg_out0[0*DW +: DW], 32'h11BB_33DD);
        check("strb_wr_en", wstb, 8'b0000_0001);
        wr_strb = 4'b1111;
`endif

        // three wait states
        xfer(1, 1'b1, 8'h04, 32'hDEAD_BEEF, rd, err, waits, wstb, rstb);
        check("ws3_w_waits", waits, 3);
        check("ws3_w_wr_en", wstb, 8'b0000_0010);
        xfer(1, 1'b0, 8'h04, 32'h0, rd, err, waits, wstb, rstb);
        check("ws3_r_waits", waits, 3);
        check("ws3_r_data",  rd, 32'hDEAD_BEEF);
        check("ws3_r_rd_en", rstb, 8'b0000_0010);
        @(negedge sys_clk); check("ws3_r_rd_once", rd_en1, 8'b0);
        @(posedge sys_clk); #1;

        // abort: psel dropped during ACCESS
        paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'h1234_5678; psel1 = 1'b1; penable = 1'b0;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(posedge sys_clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        flag = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge sys_clk);
            if (pready1 || wr_en1 != '0 || rd_en1 != '0) flag = 1'b1;
        end
        check("abort_quiet", flag, 1'b0);
        check("abort_reg3",  reg_out1[3*DW +: DW], 32'h0);
        @(posedge sys_clk); #1;

        // reset mid-transfer, bus then held with penable and no SETUP
        paddr = 8'h10; pwrite = 1'b1; pwdata = 32'h0000_0077; psel1 = 1'b1; penable = 1'b0;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        flag = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge sys_clk);
            if (pready1 || pslverr1 || prdata1 != '0 || wr_en1 != '0 || rd_en1 != '0) flag = 1'b1;
        end
        check("rst_mid_quiet", flag, 1'b0);
        check("rst_mid_regs",  reg_out1 == '0, 1'b1);
        psel1 = 1'b0; penable = 1'b0;
        @(posedge sys_clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
